// File: rtl/cellrv32_icache_memory.sv
// Instruction-cache storage array: tag, valid, data and per-word error-status memories per way,
// plus a one-bit-per-line LRU history used when the cache is 2-way set associative.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   invalidate_i          clear every valid bit (and the LRU history) in one cycle
//   host_addr_i/host_re_i host read address and read enable (read enable drives the LRU update)
//   host_rdata_o/_rstat_o word and stored error status, one cycle after the address
//   hit_o                 hit for the address presented in the previous cycle
//   ctrl_en_i             control port owns the array (refill in progress)
//   ctrl_addr_i           control access address
//   ctrl_we_i/_wdata_i/_wstat_i  write data word and its status into the replacement way
//   ctrl_tag_we_i         write the tag of ctrl_addr_i into the replacement way
//   ctrl_valid_i/_invalid_i      set/clear the valid bit of the selected line
module cellrv32_icache_memory #(
  parameter int unsigned ICACHE_NUM_BLOCKS = 4,
  parameter int unsigned ICACHE_BLOCK_SIZE = 64,
  parameter int unsigned ICACHE_NUM_SETS   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        invalidate_i,
  input  logic [31:0] host_addr_i,
  input  logic        host_re_i,
  output logic [31:0] host_rdata_o,
  output logic        host_rstat_o,
  output logic        hit_o,
  input  logic        ctrl_en_i,
  input  logic [31:0] ctrl_addr_i,
  input  logic        ctrl_we_i,
  input  logic [31:0] ctrl_wdata_i,
  input  logic        ctrl_wstat_i,
  input  logic        ctrl_tag_we_i,
  input  logic        ctrl_valid_i,
  input  logic        ctrl_invalid_i
);

  localparam int unsigned Lines  = ICACHE_NUM_BLOCKS / ICACHE_NUM_SETS;
  localparam int unsigned Words  = ICACHE_BLOCK_SIZE / 4;
  localparam int unsigned OffW   = $clog2(Words);
  localparam int unsigned IdxW   = $clog2(Lines);
  localparam int unsigned TagW   = 32 - 2 - OffW - IdxW;
  localparam int unsigned IdxWs  = (IdxW == 0) ? 1 : IdxW;
  localparam int unsigned Depth  = Lines * Words;
  localparam int unsigned WAddrW = (IdxW + OffW == 0) ? 1 : IdxW + OffW;

  if ((ICACHE_NUM_SETS != 1 && ICACHE_NUM_SETS != 2) ||
      (ICACHE_NUM_BLOCKS == 0) || ((ICACHE_NUM_BLOCKS & (ICACHE_NUM_BLOCKS - 1)) != 0) ||
      (ICACHE_NUM_BLOCKS < ICACHE_NUM_SETS) ||
      (ICACHE_BLOCK_SIZE < 4) || ((ICACHE_BLOCK_SIZE & (ICACHE_BLOCK_SIZE - 1)) != 0))
  begin : g_param_err
    $error("cellrv32_icache_memory: unsupported parameter combination");
  end

  // Shift-and-mask extraction keeps zero-width index/offset fields legal.
  function automatic logic [IdxWs-1:0] get_idx(input logic [31:0] a);
    logic [31:0] t;
    t = (a >> (2 + OffW)) & 32'(Lines - 1);
    return t[IdxWs-1:0];
  endfunction

  function automatic logic [WAddrW-1:0] get_waddr(input logic [31:0] a);
    logic [31:0] t;
    t = (a >> 2) & 32'(Depth - 1);
    return t[WAddrW-1:0];
  endfunction

  function automatic logic [TagW-1:0] get_tag(input logic [31:0] a);
    logic [31:0] t;
    t = a >> (2 + OffW + IdxW);
    return t[TagW-1:0];
  endfunction

  logic [31:0]                rd_addr;
  logic [31:0]                acc_addr_q;
  logic                       ctrl_en_q;
  logic                       host_re_q;
  logic [ICACHE_NUM_SETS-1:0] valid_q [Lines];
  logic [ICACHE_NUM_SETS-1:0] rd_valid_q;
  logic [Lines-1:0]           lru_q;  // most-recently-used way per line
  logic [1:0]                 c_valid2;
  logic                       way_sel;
  logic [ICACHE_NUM_SETS-1:0] way_hit;
  logic [1:0]                 hit2;
  logic                       hit_way;
  logic [31:0]                way_data [ICACHE_NUM_SETS];
  logic                       way_stat [ICACHE_NUM_SETS];

  logic [IdxWs-1:0]  c_idx, r_idx, a_idx;
  logic [WAddrW-1:0] c_waddr, r_waddr;
  logic [TagW-1:0]   c_tag, a_tag;

  assign rd_addr = ctrl_en_i ? ctrl_addr_i : host_addr_i;
  assign c_idx   = get_idx(ctrl_addr_i);
  assign c_waddr = get_waddr(ctrl_addr_i);
  assign c_tag   = get_tag(ctrl_addr_i);
  assign r_idx   = get_idx(rd_addr);
  assign r_waddr = get_waddr(rd_addr);
  assign a_idx   = get_idx(acc_addr_q);
  assign a_tag   = get_tag(acc_addr_q);

  // Replacement way: first invalid way, else the way that is not most-recently-used. Valid and
  // LRU only change at refill end, so the choice is stable across a whole refill.
  always_comb begin
    c_valid2 = 2'(valid_q[c_idx]);
    way_sel  = 1'b0;
    if (ICACHE_NUM_SETS == 2) begin
      if (!c_valid2[0]) begin
        way_sel = 1'b0;
      end else if (!c_valid2[1]) begin
        way_sel = 1'b1;
      end else begin
        way_sel = ~lru_q[c_idx];
      end
    end
  end

  for (genvar s = 0; s < ICACHE_NUM_SETS; s++) begin : g_way
    logic [TagW-1:0] tag_mem  [Lines];
    logic [31:0]     data_mem [Depth];
    logic            stat_mem [Depth];
    logic [TagW-1:0] tag_q;
    logic [31:0]     data_q;
    logic            stat_q;
    logic            sel;

    assign sel = (way_sel == 1'(s));

    always_ff @(posedge clk_i) begin
      if (ctrl_en_i && sel) begin
        if (ctrl_we_i) begin
          data_mem[c_waddr] <= ctrl_wdata_i;
          stat_mem[c_waddr] <= ctrl_wstat_i;
        end
        if (ctrl_tag_we_i) begin
          tag_mem[c_idx] <= c_tag;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        tag_q  <= '0;
        data_q <= '0;
        stat_q <= 1'b0;
      end else begin
        tag_q  <= tag_mem[r_idx];
        data_q <= data_mem[r_waddr];
        stat_q <= stat_mem[r_waddr];
      end
    end

    assign way_hit[s]  = rd_valid_q[s] && (tag_q == a_tag);
    assign way_data[s] = data_q;
    assign way_stat[s] = stat_q;
  end

  assign hit2    = 2'(way_hit);
  assign hit_way = hit2[1] & ~hit2[0];
  assign hit_o   = (|way_hit) & ~ctrl_en_q;

  always_comb begin
    host_rdata_o = way_data[0];
    host_rstat_o = way_stat[0];
    if (ICACHE_NUM_SETS == 2 && hit_way) begin
      host_rdata_o = way_data[ICACHE_NUM_SETS-1];
      host_rstat_o = way_stat[ICACHE_NUM_SETS-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_addr_q <= '0;
      ctrl_en_q  <= 1'b0;
      host_re_q  <= 1'b0;
      rd_valid_q <= '0;
    end else begin
      acc_addr_q <= rd_addr;
      ctrl_en_q  <= ctrl_en_i;
      host_re_q  <= host_re_i;
      rd_valid_q <= valid_q[r_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || invalidate_i) begin
      for (int unsigned l = 0; l < Lines; l++) begin
        valid_q[l] <= '0;
      end
      lru_q <= '0;
    end else begin
      if (ICACHE_NUM_SETS == 2 && host_re_q && hit_o) begin
        lru_q[a_idx] <= hit_way;
      end
      // Later assignments win, so a control update overrides the host LRU update.
      if (ctrl_en_i) begin
        for (int unsigned s = 0; s < ICACHE_NUM_SETS; s++) begin
          if (way_sel == 1'(s)) begin
            if (ctrl_invalid_i) begin
              valid_q[c_idx][s] <= 1'b0;
            end else if (ctrl_valid_i) begin
              valid_q[c_idx][s] <= 1'b1;
            end
          end
        end
        if (ICACHE_NUM_SETS == 2 && !ctrl_invalid_i && ctrl_valid_i) begin
          lru_q[c_idx] <= way_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_cellrv32_icache_memory.sv
// Directed bench: a direct-mapped instance (defaults) and a 2-way instance (4 blocks).
module tb_cellrv32_icache_memory;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // direct-mapped instance signals
  logic        a_inv, a_re, a_cen, a_we, a_wstat, a_tag_we, a_valid, a_cinv;
  logic [31:0] a_haddr, a_caddr, a_wdata;
  logic [31:0] a_rdata;
  logic        a_rstat, a_hit;

  // 2-way instance signals
  logic        b_inv, b_re, b_cen, b_we, b_wstat, b_tag_we, b_valid, b_cinv;
  logic [31:0] b_haddr, b_caddr, b_wdata;
  logic [31:0] b_rdata;
  logic        b_rstat, b_hit;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  cellrv32_icache_memory dut (
    .clk_i(clk), .rst_i(rst), .invalidate_i(a_inv),
    .host_addr_i(a_haddr), .host_re_i(a_re),
    .host_rdata_o(a_rdata), .host_rstat_o(a_rstat), .hit_o(a_hit),
    .ctrl_en_i(a_cen), .ctrl_addr_i(a_caddr), .ctrl_we_i(a_we), .ctrl_wdata_i(a_wdata),
    .ctrl_wstat_i(a_wstat), .ctrl_tag_we_i(a_tag_we), .ctrl_valid_i(a_valid),
    .ctrl_invalid_i(a_cinv)
  );

  cellrv32_icache_memory #(
    .ICACHE_NUM_BLOCKS(4), .ICACHE_BLOCK_SIZE(64), .ICACHE_NUM_SETS(2)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .invalidate_i(b_inv),
    .host_addr_i(b_haddr), .host_re_i(b_re),
    .host_rdata_o(b_rdata), .host_rstat_o(b_rstat), .hit_o(b_hit),
    .ctrl_en_i(b_cen), .ctrl_addr_i(b_caddr), .ctrl_we_i(b_we), .ctrl_wdata_i(b_wdata),
    .ctrl_wstat_i(b_wstat), .ctrl_tag_we_i(b_tag_we), .ctrl_valid_i(b_valid),
    .ctrl_invalid_i(b_cinv)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic a_idle();
    a_cen = 0; a_we = 0; a_wstat = 0; a_tag_we = 0; a_valid = 0; a_cinv = 0; a_inv = 0;
    a_caddr = '0; a_wdata = '0;
  endtask

  task automatic b_idle();
    b_cen = 0; b_we = 0; b_wstat = 0; b_tag_we = 0; b_valid = 0; b_cinv = 0; b_inv = 0;
    b_caddr = '0; b_wdata = '0;
  endtask

  // 16-word refill; errw selects the word flagged as bus error (-1 = none).
  task automatic a_refill(input logic [31:0] base, input int errw, input logic inv_last,
                          input logic cinv_last);
    for (int i = 0; i < 16; i++) begin
      a_cen    = 1'b1;
      a_we     = 1'b1;
      a_caddr  = base + 32'(4 * i);
      a_wdata  = 32'hA000_0000 + 32'(i);
      a_wstat  = (i == errw);
      a_tag_we = (i == 15);
      a_valid  = (i == 15);
      a_inv    = inv_last && (i == 15);
      a_cinv   = cinv_last && (i == 15);
      tick();
    end
    a_idle();
  endtask

  task automatic a_read(input logic [31:0] addr);
    a_haddr = addr;
    a_re    = 1'b1;
    tick();
  endtask

  // Single-cycle line fill: word, tag and valid together.
  task automatic b_fill(input logic [31:0] addr, input logic [31:0] data);
    b_cen = 1; b_we = 1; b_tag_we = 1; b_valid = 1; b_caddr = addr; b_wdata = data;
    tick();
    b_idle();
  endtask

  task automatic b_read(input logic [31:0] addr, input logic re);
    b_haddr = addr;
    b_re    = re;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_idle(); b_idle();
    a_haddr = 32'h0000_0100; a_re = 1'b0;
    b_haddr = 32'h0000_0100; b_re = 1'b0;
    tick();
    chk("a_rst_hit", 32'(a_hit), 32'd0);
    chk("a_rst_rdata", a_rdata, 32'h0);
    chk("a_rst_rstat", 32'(a_rstat), 32'd0);
    chk("b_rst_hit", 32'(b_hit), 32'd0);
    chk("b_rst_rdata", b_rdata, 32'h0);
    chk("b_rst_rstat", 32'(b_rstat), 32'd0);
    rst = 1'b0;

    // direct mapped: cold miss
    a_read(32'h0000_0100);
    chk("a_cold_miss", 32'(a_hit), 32'd0);

    // refill 0x140 and read word 2
    a_refill(32'h0000_0140, -1, 1'b0, 1'b0);
    a_read(32'h0000_0148);
    chk("a_fill_hit", 32'(a_hit), 32'd1);
    chk("a_fill_rdata", a_rdata, 32'hA000_0002);
    chk("a_fill_rstat", 32'(a_rstat), 32'd0);

    a_read(32'h0000_0240);
    chk("a_other_tag_miss", 32'(a_hit), 32'd0);

    // control port owning the array suppresses the hit
    a_re = 1'b0; a_cen = 1'b1; a_caddr = 32'h0000_0148;
    tick();
    a_idle();
    chk("a_ctrl_gate_hit", 32'(a_hit), 32'd0);
    chk("a_ctrl_gate_rdata", a_rdata, 32'hA000_0002);

    // refill with a bus error on word 3
    a_refill(32'h0000_0140, 3, 1'b0, 1'b0);
    a_read(32'h0000_014C);
    chk("a_err_hit", 32'(a_hit), 32'd1);
    chk("a_err_rstat", 32'(a_rstat), 32'd1);
    chk("a_err_rdata", a_rdata, 32'hA000_0003);
    a_read(32'h0000_0150);
    chk("a_noerr_rstat", 32'(a_rstat), 32'd0);
    chk("a_noerr_rdata", a_rdata, 32'hA000_0004);

    // global invalidate, then refill restores
    a_re = 1'b0; a_inv = 1'b1;
    tick();
    a_inv = 1'b0;
    a_read(32'h0000_0148);
    chk("a_inv_miss", 32'(a_hit), 32'd0);
    a_refill(32'h0000_0140, -1, 1'b0, 1'b0);
    a_read(32'h0000_0148);
    chk("a_refill_hit", 32'(a_hit), 32'd1);

    // per-line invalidate through the control port
    a_re = 1'b0; a_cen = 1'b1; a_caddr = 32'h0000_0140; a_cinv = 1'b1;
    tick();
    a_idle();
    a_read(32'h0000_0148);
    chk("a_cinv_miss", 32'(a_hit), 32'd0);
    a_refill(32'h0000_0140, -1, 1'b0, 1'b0);
    a_read(32'h0000_0148);
    chk("a_cinv_refill_hit", 32'(a_hit), 32'd1);

    // invalidate_i beats ctrl_valid_i on the last word
    a_refill(32'h0000_0140, -1, 1'b1, 1'b0);
    a_read(32'h0000_0148);
    chk("a_inv_vs_valid", 32'(a_hit), 32'd0);

    // ctrl_invalid_i beats ctrl_valid_i on the last word
    a_refill(32'h0000_0140, -1, 1'b0, 1'b1);
    a_read(32'h0000_0148);
    chk("a_cinv_vs_valid", 32'(a_hit), 32'd0);
    a_re = 1'b0;

    // 2-way: 0x000 -> way 0, 0x080 -> way 1, both index 0
    b_fill(32'h0000_0000, 32'h1111_0000);
    b_fill(32'h0000_0080, 32'h2222_0000);
    b_read(32'h0000_0080, 1'b0);
    chk("b_way1_hit", 32'(b_hit), 32'd1);
    chk("b_way1_rdata", b_rdata, 32'h2222_0000);
    b_read(32'h0000_0000, 1'b1);
    chk("b_way0_hit", 32'(b_hit), 32'd1);
    chk("b_way0_rdata", b_rdata, 32'h1111_0000);
    // LRU takes the host hit at the end of this cycle
    b_re = 1'b0;
    tick();
    b_fill(32'h0000_0100, 32'h3333_0000);
    b_read(32'h0000_0000, 1'b0);
    chk("b_keep_000_hit", 32'(b_hit), 32'd1);
    chk("b_keep_000_rdata", b_rdata, 32'h1111_0000);
    b_read(32'h0000_0100, 1'b0);
    chk("b_new_100_hit", 32'(b_hit), 32'd1);
    chk("b_new_100_rdata", b_rdata, 32'h3333_0000);
    b_read(32'h0000_0080, 1'b0);
    chk("b_evicted_080_miss", 32'(b_hit), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
